sopc_run_ctrl: RTL and testbench

Synthesizable run controller for the OpenMIPS minimal SOPC. It replaces the fixed-delay reset and fixed-runtime scheme of the current bench. The block sequences staggered reset release for N sub-block reset channels, counts run cycles, and ends the run on one of two events: a CPU halt (the fetch PC self-loops) or a parameterised cycle timeout. It sits between the top-level clk/rst and the SOPC sub-blocks, and the bench and FPGA wrapper both use it.

---
 rtl/sopc_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sopc_run_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_run_ctrl.sv
// ============================================================================
// sopc_run_ctrl : staggered reset release, run-cycle counting, halt/timeout end
// Revision 1.0
// ============================================================================
`default_nettype none

module sopc_run_ctrl #(
  parameter int RST_HOLD_CYCLES = 10,
  parameter int CHANNELS        = 2,
  parameter int STAGGER         = 4,
  parameter int TIMEOUT_CYCLES  = 500,
  parameter int HALT_REPEAT     = 8,
  parameter int CNT_WIDTH       = 32,
  parameter int PC_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  pc_i,
  input  logic                 pc_valid_i,
  input  logic                 restart_i,
  output logic [CHANNELS-1:0]  sub_rst_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 halted_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [31:0]          HOLD_LAST    = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0]          REL_LAST     = 32'((CHANNELS - 1) * STAGGER);
  localparam logic [31:0]          STABLE_LAST  = 32'(HALT_REPEAT - 2);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

  state_t                state, state_next;
  logic [31:0]           hold_cnt, hold_cnt_next;
  logic [31:0]           rel_cnt, rel_cnt_next;
  logic [31:0]           stable_cnt, stable_cnt_next;
  logic [PC_WIDTH-1:0]   last_pc, last_pc_next;
  logic                  have_last, have_last_next;
  logic [CHANNELS-1:0]   sub_rst_next;
  logic                  running_next, done_next, halted_next, timeout_next;
  logic [CNT_WIDTH-1:0]  cycle_cnt_next;
  logic                  pc_match, halt_hit, timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      rel_cnt     <= '0;
      stable_cnt  <= '0;
      last_pc     <= '0;
      have_last   <= 1'b0;
      sub_rst_o   <= '1;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      halted_o    <= 1'b0;
      timeout_o   <= 1'b0;
      cycle_cnt_o <= '0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      rel_cnt     <= rel_cnt_next;
      stable_cnt  <= stable_cnt_next;
      last_pc     <= last_pc_next;
      have_last   <= have_last_next;
      sub_rst_o   <= sub_rst_next;
      running_o   <= running_next;
      done_o      <= done_next;
      halted_o    <= halted_next;
      timeout_o   <= timeout_next;
      cycle_cnt_o <= cycle_cnt_next;
    end
  end

  // The halting sample is the one that would push stable_cnt to HALT_REPEAT-1.
  always_comb begin
    pc_match    = pc_valid_i && have_last && (pc_i == last_pc);
    halt_hit    = pc_match && (stable_cnt == STABLE_LAST);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt_o == TIMEOUT_LAST);
  end

  always_comb begin
    state_next      = state;
    hold_cnt_next   = hold_cnt;
    rel_cnt_next    = rel_cnt;
    stable_cnt_next = stable_cnt;
    last_pc_next    = last_pc;
    have_last_next  = have_last;
    sub_rst_next    = sub_rst_o;
    running_next    = running_o;
    done_next       = done_o;
    halted_next     = halted_o;
    timeout_next    = timeout_o;
    cycle_cnt_next  = cycle_cnt_o;

    case (state)
      S_HOLD: begin
        hold_cnt_next = hold_cnt + 32'd1;
        if (hold_cnt == HOLD_LAST) begin
          state_next   = S_RELEASE;
          rel_cnt_next = '0;
        end
      end

      S_RELEASE: begin
        rel_cnt_next = rel_cnt + 32'd1;
        for (int k = 0; k < CHANNELS; k++) begin
          if (rel_cnt == 32'(k * STAGGER)) sub_rst_next[k] = 1'b0;
        end
        if (rel_cnt == REL_LAST) begin
          state_next   = S_RUN;
          running_next = 1'b1;
        end
      end

      S_RUN: begin
        if (cycle_cnt_o != CNT_MAX) cycle_cnt_next = cycle_cnt_o + 1'b1;
        // Invalid cycles leave the PC history untouched so gaps do not reset a run.
        if (pc_valid_i) begin
          stable_cnt_next = pc_match ? stable_cnt + 32'd1 : '0;
          last_pc_next    = pc_i;
          have_last_next  = 1'b1;
        end
        if (halt_hit || timeout_hit) begin
          state_next   = S_DONE;
          done_next    = 1'b1;
          running_next = 1'b0;
          sub_rst_next = '1;
          halted_next  = halt_hit;
          timeout_next = timeout_hit && !halt_hit;
        end
      end

      S_DONE: begin
        if (restart_i) begin
          state_next      = S_HOLD;
          hold_cnt_next   = '0;
          cycle_cnt_next  = '0;
          done_next       = 1'b0;
          halted_next     = 1'b0;
          timeout_next    = 1'b0;
          stable_cnt_next = '0;
          have_last_next  = 1'b0;
          sub_rst_next    = '1;
        end
      end

      default: state_next = S_HOLD;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sopc_run_ctrl.sv
// ============================================================================
// tb_sopc_run_ctrl : scoreboard bench for sopc_run_ctrl (default and TIMEOUT=15)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sopc_run_ctrl;

  typedef logic [37:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        restart_i = 1'b0;

  logic [1:0]  sub_rst_a, sub_rst_b;
  logic        running_a, done_a, halted_a, timeout_a;
  logic        running_b, done_b, halted_b, timeout_b;
  logic [31:0] cycle_a, cycle_b;

  vec_t obs_a, obs_b;
  assign obs_a = {sub_rst_a, running_a, done_a, halted_a, timeout_a, cycle_a};
  assign obs_b = {sub_rst_b, running_b, done_b, halted_b, timeout_b, cycle_b};

  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sopc_run_ctrl dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .restart_i(restart_i),
    .sub_rst_o(sub_rst_a), .running_o(running_a), .done_o(done_a),
    .halted_o(halted_a), .timeout_o(timeout_a), .cycle_cnt_o(cycle_a)
  );

  sopc_run_ctrl #(.TIMEOUT_CYCLES(15)) dut_t (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .restart_i(restart_i),
    .sub_rst_o(sub_rst_b), .running_o(running_b), .done_o(done_b),
    .halted_o(halted_b), .timeout_o(timeout_b), .cycle_cnt_o(cycle_b)
  );

  function automatic vec_t mk(logic [1:0] sr, logic r, logic d, logic h, logic t, int cc);
    return {sr, r, d, h, t, 32'(cc)};
  endfunction

  // Expected outputs after edge e (e=1 first edge after rst/restart), pc_valid held low.
  function automatic vec_t exp_release(int e);
    logic [1:0] sr;
    sr = (e <= 10) ? 2'b11 : ((e <= 14) ? 2'b10 : 2'b00);
    return mk(sr, e >= 15, 1'b0, 1'b0, 1'b0, (e >= 16) ? e - 15 : 0);
  endfunction

  task automatic enter_run();
    pc_valid_i = 1'b0;
    restart_i  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t e;
    rst = 1'b1;
    pc_valid_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(mk(2'b11, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs_a, e);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      exp_q.push_back(exp_release(i));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL release E%0d got=%h want=%h", i, obs_a, e);
      end
    end
  endtask

  task automatic test_halt();
    vec_t e;
    enter_run();
    for (int i = 1; i <= 30; i++) begin
      pc_valid_i = 1'b1;
      pc_i = (i <= 16) ? 32'((i - 1) * 4) : 32'h40;
      if (i < 24) exp_q.push_back(mk(2'b00, 1, 0, 0, 0, i));
      else        exp_q.push_back(mk(2'b11, 0, 1, 1, 0, 24));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL halt run_edge=%0d got=%h want=%h", i, obs_a, e);
      end
    end
    pc_valid_i = 1'b0;
  endtask

  task automatic test_timeout();
    vec_t e;
    enter_run();
    for (int i = 1; i <= 550; i++) begin
      pc_valid_i = 1'b1;
      pc_i = 32'(i * 4);
      if (i < 500) exp_q.push_back(mk(2'b00, 1, 0, 0, 0, i));
      else         exp_q.push_back(mk(2'b11, 0, 1, 0, 1, 500));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL timeout run_edge=%0d got=%h want=%h", i, obs_a, e);
      end
    end
    pc_valid_i = 1'b0;
  endtask

  task automatic test_valid_gaps();
    vec_t e;
    enter_run();
    for (int i = 1; i <= 20; i++) begin
      pc_i = 32'h40;
      pc_valid_i = (i % 2 == 1);
      // Both instances: halt on the 8th valid sample; at TIMEOUT=15 halt must win.
      if (i < 15) begin
        exp_q.push_back(mk(2'b00, 1, 0, 0, 0, i));
        exp_q.push_back(mk(2'b00, 1, 0, 0, 0, i));
      end else begin
        exp_q.push_back(mk(2'b11, 0, 1, 1, 0, 15));
        exp_q.push_back(mk(2'b11, 0, 1, 1, 0, 15));
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL gaps run_edge=%0d got=%h want=%h", i, obs_a, e);
      end
      e = exp_q.pop_front();
      total++;
      if (obs_b !== e) begin
        bad++;
        $display("FAIL gaps_tie run_edge=%0d got=%h want=%h", i, obs_b, e);
      end
    end
    pc_valid_i = 1'b0;
  endtask

  task automatic test_mid_run_reset();
    vec_t e;
    enter_run();
    for (int i = 1; i <= 100; i++) begin
      exp_q.push_back(mk(2'b00, 1, 0, 0, 0, i));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL prerst run_edge=%0d got=%h want=%h", i, obs_a, e);
      end
    end
    rst = 1'b1;
    exp_q.push_back(mk(2'b11, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (obs_a !== e) begin
      bad++;
      $display("FAIL midrun_rst got=%h want=%h", obs_a, e);
    end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(exp_release(i));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL rerelease E%0d got=%h want=%h", i, obs_a, e);
      end
    end
  endtask

  task automatic test_restart();
    vec_t e;
    enter_run();
    for (int i = 1; i <= 10; i++) begin
      pc_i = 32'h40;
      pc_valid_i = 1'b1;
      restart_i = (i == 3);
      if (i < 8) exp_q.push_back(mk(2'b00, 1, 0, 0, 0, i));
      else       exp_q.push_back(mk(2'b11, 0, 1, 1, 0, 8));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL restart_run run_edge=%0d got=%h want=%h", i, obs_a, e);
      end
    end
    pc_valid_i = 1'b0;
    restart_i = 1'b1;
    exp_q.push_back(mk(2'b11, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (obs_a !== e) begin
      bad++;
      $display("FAIL restart_edge got=%h want=%h", obs_a, e);
    end
    restart_i = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      exp_q.push_back(exp_release(i));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL restart_release E%0d got=%h want=%h", i, obs_a, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_halt();
    test_timeout();
    test_valid_gaps();
    test_mid_run_reset();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
